// File: rtl/regfile_mp.sv
// regfile_mp: parametrised multi-read-port GPR file, clear engine, snapshot.
// Optional build macro REGFILE_BYPASS_EN adds write-to-read forwarding.
module regfile_mp #(
  parameter int XLEN      = 32,
  parameter int DEPTH     = 32,
  parameter int NREAD     = 2,
  parameter int SNAP_REGS = 8,
  localparam int AW       = $clog2(DEPTH)
) (
  input  logic                      CLK,
  input  logic                      RST,
  input  logic [NREAD*AW-1:0]       RA,
  output logic [NREAD*XLEN-1:0]     RD,
  input  logic                      WE,
  input  logic [AW-1:0]             WA,
  input  logic [XLEN-1:0]           WD,
  output logic                      W_READY,
  input  logic                      CLR_REQ,
  output logic                      BUSY,
  output logic [SNAP_REGS*XLEN-1:0] SNAP
);

  typedef enum logic {
    S_IDLE  = 1'b0,
    S_CLEAR = 1'b1
  } state_t;

  localparam logic [AW-1:0] IDX_ONE  = AW'(1);
  localparam logic [AW-1:0] IDX_LAST = AW'(DEPTH - 1);

  state_t          r_state;
  state_t          w_state_nxt;
  logic [AW-1:0]   r_idx;
  logic [AW-1:0]   w_idx_nxt;
  logic [XLEN-1:0] r_mem [DEPTH];
  logic            w_wr;

  assign W_READY = (r_state == S_IDLE) && !RST;
  assign BUSY    = (r_state == S_CLEAR);
  assign w_wr    = WE && W_READY && (WA != '0);

  always_ff @(posedge CLK) begin
    if (RST) begin
      r_state <= S_IDLE;
      r_idx   <= IDX_ONE;
    end else begin
      r_state <= w_state_nxt;
      r_idx   <= w_idx_nxt;
    end
  end

  always_comb begin
    w_state_nxt = r_state;
    w_idx_nxt   = r_idx;
    unique case (r_state)
      S_IDLE: begin
        if (CLR_REQ) begin
          w_state_nxt = S_CLEAR;
          w_idx_nxt   = IDX_ONE;
        end
      end
      S_CLEAR: begin
        if (r_idx == IDX_LAST) begin
          w_state_nxt = S_IDLE;
          w_idx_nxt   = IDX_ONE;
        end else begin
          w_idx_nxt = r_idx + IDX_ONE;
        end
      end
      default: begin
        w_state_nxt = S_IDLE;
        w_idx_nxt   = IDX_ONE;
      end
    endcase
  end

  // Writes and the clear walk never overlap: W_READY is low in CLEAR.
  always_ff @(posedge CLK) begin
    if (RST) begin
      for (int i = 0; i < DEPTH; i++) begin
        r_mem[i] <= '0;
      end
    end else begin
      if (w_wr) begin
        r_mem[WA] <= WD;
      end
      if (r_state == S_CLEAR) begin
        r_mem[r_idx] <= '0;
      end
    end
  end

  for (genvar p = 0; p < NREAD; p++) begin : g_rd
    logic [AW-1:0]   w_ra;
    logic [XLEN-1:0] w_rdata;
    logic [XLEN-1:0] r_rd;

    assign w_ra = RA[p*AW +: AW];

    always_comb begin
      w_rdata = '0;
      if (w_ra != '0) begin
        w_rdata = r_mem[w_ra];
      end
`ifdef REGFILE_BYPASS_EN
      if (w_wr && (w_ra == WA)) begin
        w_rdata = WD;
      end
`endif
    end

    always_ff @(posedge CLK) begin
      if (RST) begin
        r_rd <= '0;
      end else begin
        r_rd <= w_rdata;
      end
    end

    assign RD[p*XLEN +: XLEN] = r_rd;
  end

  // Highest register lands in the most significant word.
  for (genvar k = 0; k < SNAP_REGS; k++) begin : g_snap
    assign SNAP[k*XLEN +: XLEN] = r_mem[DEPTH-SNAP_REGS+k];
  end

endmodule

// File: tb/tb_regfile_mp.sv
// tb_regfile_mp: directed + random checks of regfile_mp against an array model.
// Second instance covers DEPTH=16 / NREAD=3 snapshot and port independence.
module tb_regfile_mp;

`ifdef REGFILE_BYPASS_EN
  localparam bit BYP = 1'b1;
`else
  localparam bit BYP = 1'b0;
`endif

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic         rst = 1'b1;
  logic [9:0]   ra_a = '0;
  logic [63:0]  rd_a;
  logic         we_a = 1'b0;
  logic [4:0]   wa_a = '0;
  logic [31:0]  wd_a = '0;
  logic         wrdy_a;
  logic         clr_a = 1'b0;
  logic         busy_a;
  logic [255:0] snap_a;

  logic [11:0]  ra_b = '0;
  logic [95:0]  rd_b;
  logic         we_b = 1'b0;
  logic [3:0]   wa_b = '0;
  logic [31:0]  wd_b = '0;
  logic         wrdy_b;
  logic         clr_b = 1'b0;
  logic         busy_b;
  logic [255:0] snap_b;

  regfile_mp #(
    .XLEN(32), .DEPTH(32), .NREAD(2), .SNAP_REGS(8)
  ) u_a (
    .CLK(clk), .RST(rst), .RA(ra_a), .RD(rd_a),
    .WE(we_a), .WA(wa_a), .WD(wd_a), .W_READY(wrdy_a),
    .CLR_REQ(clr_a), .BUSY(busy_a), .SNAP(snap_a)
  );

  regfile_mp #(
    .XLEN(32), .DEPTH(16), .NREAD(3), .SNAP_REGS(8)
  ) u_b (
    .CLK(clk), .RST(rst), .RA(ra_b), .RD(rd_b),
    .WE(we_b), .WA(wa_b), .WD(wd_b), .W_READY(wrdy_b),
    .CLR_REQ(clr_b), .BUSY(busy_b), .SNAP(snap_b)
  );

  int n_checks = 0;
  int n_err    = 0;

  // Reference: register contents plus remaining clear cycles (0 = idle).
  logic [31:0] m [32];
  int          clr_left = 0;
  bit          m_valid  = 1'b0;

  task automatic chk(string tag, logic [255:0] obs, logic [255:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s: got %0h expected %0h", tag, obs, exp);
    end
  endtask

  function automatic logic [31:0] exp_rd(bit [4:0] ra, bit wr,
                                         bit [4:0] wa, bit [31:0] wd,
                                         bit r);
    if (r || ra == 0) return 32'h0;
    if (BYP && wr && ra == wa) return wd;
    return m[ra];
  endfunction

  task automatic step_a(bit we, bit [4:0] wa, bit [31:0] wd, bit clr,
                        bit r, bit [4:0] ra0, bit [4:0] ra1);
    logic [31:0]  e0, e1;
    logic [255:0] es;
    bit           rdy, wr;
    rst = r; we_a = we; wa_a = wa; wd_a = wd; clr_a = clr;
    ra_a = {ra1, ra0};
    @(negedge clk);
    rdy = (clr_left == 0) && !r;
    wr  = we && rdy && (wa != 0);
    chk("w_ready", wrdy_a, rdy);
    if (m_valid) begin
      chk("busy", busy_a, clr_left != 0);
      for (int k = 0; k < 8; k++) es[k*32 +: 32] = m[24+k];
      chk("snap", snap_a, es);
    end
    e0 = exp_rd(ra0, wr, wa, wd, r);
    e1 = exp_rd(ra1, wr, wa, wd, r);
    @(posedge clk);
    if (r) begin
      foreach (m[i]) m[i] = 32'h0;
      clr_left = 0;
      m_valid  = 1'b1;
    end else if (clr_left > 0) begin
      m[32 - clr_left] = 32'h0;
      clr_left--;
    end else begin
      if (wr) m[wa] = wd;
      if (clr) clr_left = 31;
    end
    #1;
    chk("rd0", rd_a[31:0], e0);
    chk("rd1", rd_a[63:32], e1);
  endtask

  task automatic step_b(bit we, bit [3:0] wa, bit [31:0] wd,
                        bit [3:0] r0, bit [3:0] r1, bit [3:0] r2);
    we_b = we; wa_b = wa; wd_b = wd;
    ra_b = {r2, r1, r0};
    @(posedge clk);
    #1;
  endtask

  initial begin
    int n;
    bit [4:0] wa, r0, r1;
    // Reset and zero register
    step_a(0, 0, 0, 0, 1, 0, 0);
    step_a(1, 4, 32'h55, 1, 1, 0, 0);
    step_a(0, 0, 0, 0, 0, 5, 0);
    step_a(0, 0, 0, 0, 0, 5, 0);
    // Basic write/read and dropped write to r0
    step_a(1, 3, 32'hDEADBEEF, 0, 0, 0, 0);
    step_a(0, 0, 0, 0, 0, 3, 0);
    step_a(1, 0, 32'h1234, 0, 0, 3, 0);
    step_a(0, 0, 0, 0, 0, 0, 0);
    // Same-cycle write/read of reg 7
    step_a(1, 7, 32'h11, 0, 0, 0, 0);
    step_a(1, 7, 32'hA5A5A5A5, 0, 0, 7, 7);
    step_a(0, 0, 0, 0, 0, 7, 7);
    // Random traffic
    for (int i = 0; i < 300; i++) begin
      wa = 5'($urandom_range(0, 31));
      r0 = ($urandom % 3 == 0) ? wa : 5'($urandom_range(0, 31));
      r1 = 5'($urandom_range(0, 31));
      step_a(1'($urandom % 2), wa, $urandom, ($urandom % 25) == 0,
             ($urandom % 80) == 0, r0, r1);
    end
    n = 0;
    while (clr_left != 0 && n < 100) begin
      step_a(0, 0, 0, 0, 0, 0, 0);
      n++;
    end
    chk("drain", clr_left, 0);
    // Clear engine: fill, pulse, count busy cycles
    for (int i = 1; i < 32; i++) step_a(1, 5'(i), i, 0, 0, 0, 0);
    step_a(0, 0, 0, 1, 0, 9, 31);
    n = 0;
    while (busy_a === 1'b1 && n < 100) begin
      step_a(1, 9, 32'hFF, 1, 0, 9, 5'(n));
      n++;
    end
    chk("busy_len", n, 31);
    for (int i = 0; i < 32; i += 2) step_a(0, 0, 0, 0, 0, 5'(i), 5'(i + 1));
    chk("reg9", m[9], 0);
    // Reset in the middle of a clear
    for (int i = 1; i < 32; i++) step_a(1, 5'(i), ~i, 0, 0, 0, 0);
    step_a(0, 0, 0, 1, 0, 0, 0);
    for (int i = 0; i < 10; i++) step_a(0, 0, 0, 0, 0, 20, 31);
    step_a(0, 0, 0, 0, 1, 20, 31);
    chk("busy_rst", busy_a, 0);
    for (int i = 0; i < 32; i += 2) step_a(0, 0, 0, 0, 0, 5'(i), 5'(i + 1));
    step_a(1, 12, 32'h600D, 0, 0, 0, 0);
    step_a(0, 0, 0, 0, 0, 12, 0);
    // DEPTH=16, NREAD=3 instance
    chk("b_snap0", snap_b, 0);
    chk("b_rdy", wrdy_b, 1);
    chk("b_busy", busy_b, 0);
    step_b(1, 15, 32'hCAFEF00D, 0, 0, 0);
    chk("b_snap_top", snap_b[255:224], 32'hCAFEF00D);
    step_b(1, 8, 32'h88, 0, 0, 0);
    chk("b_snap_lo", snap_b[31:0], 32'h88);
    step_b(1, 1, 32'h11, 0, 0, 0);
    step_b(0, 0, 0, 15, 8, 1);
    chk("b_rd0", rd_b[31:0], 32'hCAFEF00D);
    chk("b_rd1", rd_b[63:32], 32'h88);
    chk("b_rd2", rd_b[95:64], 32'h11);
    step_b(0, 0, 0, 15, 15, 15);
    chk("b_same", rd_b, {3{32'hCAFEF00D}});
    step_b(0, 0, 0, 0, 2, 8);
    chk("b_mix", rd_b, {32'h88, 32'h0, 32'h0});
    $display("Simulation finished: %0d checks, %0d errors",
             n_checks, n_err);
    $finish;
  end

endmodule
